// File: rtl/viterbi_decoder_if.sv
// Symbol/decoded-bit handshake for the hard-decision Viterbi decoder.
// The master drives code symbols; the slave (decoder) returns decoded bits.
interface viterbi_decoder_if;
  logic [1:0] code_in_sig;
  logic       code_valid_sig;
  logic       decode_sig;
  logic       decode_valid_sig;

  modport master (
    output code_in_sig,
    output code_valid_sig,
    input  decode_sig,
    input  decode_valid_sig
  );

  modport slave (
    input  code_in_sig,
    input  code_valid_sig,
    output decode_sig,
    output decode_valid_sig
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate-1/2 K=3 (7,5) code, 4 states,
// saturating ACS with per-symbol normalisation and register-exchange survivors.
module viterbi_decoder #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 6
) (
  input  logic              clk10M_sig,
  input  logic              reset_sig,
  viterbi_decoder_if.slave  bus
);

  localparam logic [PM_W-1:0] PM_MAX    = '1;
  localparam int unsigned     CNT_W     = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [PM_W-1:0]     acs_pm [4];
  logic [TB_DEPTH-1:0] path_q [4];
  logic [TB_DEPTH-1:0] path_d [4];
  logic [CNT_W-1:0]    fill_q;
  logic [PM_W-1:0]     min_pm;
  logic [1:0]          best;

  // Encoder output for state {s1,s0} and input u: {u^s1^s0, u^s0}.
  function automatic logic [1:0] branch_code(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // Add-compare-select: next state {u,s1} is reached from {s1,0} or {s1,1};
  // ties favour the s0=0 predecessor.
  always_comb begin
    for (int unsigned ns = 0; ns < 4; ns++) begin
      logic [1:0]      ns_v;
      logic [1:0]      pred0;
      logic [1:0]      pred1;
      logic [PM_W-1:0] cand0;
      logic [PM_W-1:0] cand1;
      ns_v  = 2'(ns);
      pred0 = {ns_v[0], 1'b0};
      pred1 = {ns_v[0], 1'b1};
      cand0 = sat_add(pm_q[pred0], hamming(bus.code_in_sig, branch_code(pred0, ns_v[1])));
      cand1 = sat_add(pm_q[pred1], hamming(bus.code_in_sig, branch_code(pred1, ns_v[1])));
      if (cand1 < cand0) begin
        acs_pm[ns] = cand1;
        path_d[ns] = {path_q[pred1][TB_DEPTH-2:0], ns_v[1]};
      end else begin
        acs_pm[ns] = cand0;
        path_d[ns] = {path_q[pred0][TB_DEPTH-2:0], ns_v[1]};
      end
    end
  end

  // Best state and normalisation; strict '<' keeps the lowest index on ties.
  always_comb begin
    best   = 2'd0;
    min_pm = acs_pm[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (acs_pm[i] < min_pm) begin
        min_pm = acs_pm[i];
        best   = 2'(i);
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      pm_d[i] = acs_pm[i] - min_pm;
    end
  end

  always_ff @(posedge clk10M_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      pm_q[0] <= '0;
      for (int unsigned i = 1; i < 4; i++) pm_q[i] <= PM_MAX;
      for (int unsigned i = 0; i < 4; i++) path_q[i] <= '0;
      fill_q               <= '0;
      bus.decode_sig       <= 1'b0;
      bus.decode_valid_sig <= 1'b0;
    end else begin
      bus.decode_valid_sig <= 1'b0;
      if (bus.code_valid_sig) begin
        for (int unsigned i = 0; i < 4; i++) begin
          pm_q[i]   <= pm_d[i];
          path_q[i] <= path_d[i];
        end
        if (fill_q != FILL_LAST) fill_q <= fill_q + CNT_W'(1);
        bus.decode_valid_sig <= (fill_q == FILL_LAST);
        bus.decode_sig       <= path_d[best][TB_DEPTH-1];
      end
    end
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal) produced by the team's encoder path.
- Sits after the noise channel and the serial-to-parallel stage; consumes 2-bit code symbols and emits recovered data bits.
- Uses 4 states, Hamming branch metrics, add-compare-select with metric normalisation, and register-exchange survivor memory of depth TB_DEPTH.

Parameters:
- TB_DEPTH, 16, survivor path length in bits; decode latency in symbols; legal range 4..32.
- PM_W, 6, path-metric width in bits; metrics saturate at 2^PM_W-1.

Ports:
- clk10M_sig  input  1  symbol-rate clock; all state updates on rising edge.
- reset_sig  input  1  asynchronous, active-low reset.
- code_in_sig  input  2  received symbol {g0,g1}: bit1 = u^s1^s0, bit0 = u^s0.
- code_valid_sig  input  1  code_in_sig is sampled on each rising edge where this is 1.
- decode_sig  output  1  decoded data bit.
- decode_valid_sig  output  1  one-cycle strobe qualifying decode_sig.

Behaviour:
- Encoder convention: state s = {s1,s0}; s1 is the previous input bit, s0 the bit before it. Input u gives next state {u,s1}. The encoder starts in state 0.
- Reset (reset_sig=0, asynchronous):
  - PM[0]=0; PM[1..3]=2^PM_W-1.
  - All survivor paths are 0.
  - Fill counter is 0.
  - decode_sig=0, decode_valid_sig=0.
- Branch metric: Hamming distance (0..2) between code_in_sig and the expected output of each transition.
- ACS, per next state ns={u,s1}:
  - Predecessors are {s1,0} and {s1,1}.
  - cand = PM[pred] + BM, saturating at 2^PM_W-1.
  - Choose the smaller candidate. On a tie, choose the predecessor with s0=0.
- Normalisation: in the same cycle, subtract the minimum of the 4 new metrics from all 4. The stored minimum is therefore always 0 and no metric wraps.
- Survivor update (register exchange): path[ns] <= {path[pred][TB_DEPTH-2:0], u}. Bit 0 is the newest bit, bit TB_DEPTH-1 the oldest.
- Output select:
  - best = state with the minimum new metric; on a tie, the lowest index wins.
  - decode_sig <= new path[best][TB_DEPTH-1], registered on the same edge that samples the symbol.
- Fill counter:
  - Increments on each accepted symbol and saturates at TB_DEPTH-1.
  - decode_valid_sig <= 1 on an accepted symbol when the counter already equals TB_DEPTH-1; otherwise 0.
  - The first valid strobe follows the TB_DEPTH-th accepted symbol and carries data bit 0.
  - Every later accepted symbol produces exactly one strobe.
- Latency: data bit k is output in the cycle after symbol k+TB_DEPTH-1 (0-based) is sampled.
- code_valid_sig=0: metrics, paths and counter hold; decode_valid_sig=0; decode_sig holds its last value. Gaps of any length are legal.
- Reset mid-stream: all state returns to reset values immediately. Decoding restarts assuming the encoder is in state 0, and no stale strobes appear after release.
- No flush: the final TB_DEPTH-1 bits of a stream come out only if trailing symbols are supplied (the encoder is fed zero tail bits).

Test Plan:
- All-zero stream: 40 symbols of 2'b00 -> first decode_valid_sig in the cycle after symbol 16; 25 strobes total, all decode_sig=0; PM[0] stays 0.
- Error-free known data: encode 1,0,1,1,0,0,1,0 plus 16 zero tail bits; feed the encoded symbols -> strobes emit exactly 1,0,1,1,0,0,1,0 followed by zeros; bit-exact against the reference model.
- Sparse errors: 200 random bits encoded, with one channel bit flipped every 8 symbols -> decoded stream equals the source with zero bit errors.
- Valid gaps: same stimulus as the error-free case, with code_valid_sig low for random 0-5 cycle gaps -> identical strobe sequence; no strobe during gaps.
- Reset mid-stream: assert reset_sig for 1 cycle after 10 symbols -> decode_valid_sig=0 and all metrics/paths at reset values immediately; after release, the next strobe comes 16 symbols later and is correct for the new stream.
- Long-run normalisation: 10000 random symbols (pure noise) -> min(PM)=0 after every update; no metric ever exceeds 2^PM_W-1; strobe count = accepted symbols - 15.
